bure_decode_stage: RTL and testbench
====================================

# bure_decode_stage

Registered instruction decode stage for the Bure core. Accepts a 32-bit RV32I instruction and its PC from fetch, and drives the register-file read addresses. It generates the complete operand and control bundle consumed by `bure_alu` (`force_add`, `funct3`, `funct7`, `lhs`, `rhs`), plus writeback and memory controls. The bundle is held in a single pipeline register with valid/ready handshakes on both sides.

## Interface
- `DATA_WIDTH`, 32, width of PC, register data and operands.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  fetch presents an instruction.
- `o_ready`  out  1  stage can accept; transfer when `i_valid && o_ready`.
- `i_instr`  in  32  instruction word.
- `i_pc`  in  DATA_WIDTH  PC of `i_instr`.
- `o_rs1_addr`, `o_rs2_addr`  out  5  combinational from `i_instr[19:15]` / `[24:20]`.
- `i_rs1_data`, `i_rs2_data`  in  DATA_WIDTH  register-file read data, same cycle.
- `i_flush`  in  1  discard held and incoming instruction.
- `o_valid`  out  1  decoded bundle valid.
- `i_ready`  in  1  execute accepts; transfer when `o_valid && i_ready`.
- `o_force_add`  out  1  ALU forced add.
- `o_funct3`  out  3  ALU funct3.
- `o_funct7`  out  7  ALU funct7.
- `o_data_lhs`  out  DATA_WIDTH  ALU lhs.
- `o_data_rhs`  out  DATA_WIDTH  ALU rhs.
- `o_rd_addr`  out  5  destination register.
- `o_wb_en`  out  1  write result to `rd`; forced 0 when `rd == 0`.
- `o_mem_read`, `o_mem_write`  out  1  load / store.
- `o_store_data`  out  DATA_WIDTH  rs2 data for stores.
- `o_illegal`  out  1  unsupported opcode.

## Operation
- Supported opcodes are OP (0110011), OP-IMM (0010011), LOAD (0000011), STORE (0100011), LUI (0110111) and AUIPC (0010111). The table below gives `lhs` / `rhs` / `force_add` / `funct7` for each.
- **OP:** `lhs`=rs1, `rhs`=rs2, `funct3`/`funct7` taken from the instruction, `force_add`=0, `wb_en`=1.
- **OP-IMM:** `lhs`=rs1, `rhs`=sign-extended I-immediate.
  - For funct3 001 and 101 (shifts), `funct7`=`instr[31:25]`.
  - For all other funct3, `funct7`=0. This prevents `ADDI` with `imm[11:5]`=0100000 from decoding as `SUB`.
- **LOAD:** `force_add`=1, `lhs`=rs1, `rhs`=I-immediate, `mem_read`=1, `wb_en`=1.
- **STORE:** `force_add`=1, `lhs`=rs1, `rhs`=S-immediate `{instr[31:25],instr[11:7]}` sign-extended, `mem_write`=1, `store_data`=rs2, `wb_en`=0.
- **LUI:** `force_add`=1, `lhs`=0, `rhs`=`{instr[31:12],12'b0}`.
- **AUIPC:** same as LUI but `lhs`=`i_pc`.
- **Any other opcode:** `o_illegal`=1; `wb_en`, `mem_*`, `force_add`, `funct3`, `funct7`, `lhs`, `rhs` and `store_data` all 0. The bundle still flows through the handshake.
- **Register fields:** `funct3` for LOAD/STORE is still registered from the instruction (execute uses it for size). LUI/AUIPC register `funct3`=0 and `funct7`=0.
- **Handshake:** `o_ready = !o_valid || i_ready`, gated low while `i_flush`=1.
- **Capture:** on `i_valid && o_ready`, the bundle is registered and `o_valid`←1.
- **Drain:** on `o_valid && i_ready` with no capture, `o_valid`←0.
- **Flush:** has priority over everything: `o_valid`←0 next edge and no capture.
- **Reset:** every output register is 0, including `o_valid` and `o_illegal`. `o_ready` reads 1 once out of reset.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented with `o_valid`=1 after edge N.
- Throughput is one instruction per cycle: simultaneous drain and capture in the same cycle replaces the bundle with no bubble.
- **Backpressure:** while `o_valid && !i_ready`, all outputs hold stable and `o_ready`=0.
- **Register reads:** `o_rs*_addr` are combinational; `i_rs*_data` is sampled on the capture edge only.
- **Reset mid-operation:** asynchronous assertion clears `o_valid` immediately; the held bundle is lost.

## Test plan
- **ADD:** `0x002081B3` with rs1=5, rs2=7 → next cycle `o_valid`=1, funct3=0, funct7=0x00, lhs=5, rhs=7, rd=3, `wb_en`=1.
- **SUB, then ADDI -1:**
  - `0x402081B3` → funct7=0x20.
  - `0xFFF00093` → rhs=0xFFFFFFFF, funct7=0x00, rd=1.
- **SRAI and LUI:**
  - `0x40335293` with rs1=0x80000000 → funct3=5, funct7=0x20, rhs=3.
  - `0x123450B7` → `force_add`=1, lhs=0, rhs=0x12345000.
- **Loads and stores:**
  - `0x00812083` with rs1=0x100 → `force_add`=1, lhs=0x100, rhs=8, `mem_read`=1.
  - `0x0020A623` with rs2=0xDEAD → rhs=12, `mem_write`=1, `store_data`=0xDEAD, `wb_en`=0.
- **Backpressure and throughput:**
  - Hold `i_ready`=0 for 3 cycles with `i_valid`=1 → outputs frozen and `o_ready`=0.
  - Release → back-to-back instructions transfer one per cycle with no bubble.
- **Flush, illegal opcode, and `rd`=x0:**
  - Assert `i_flush` with `o_valid`=1 and `i_valid`=1 → `o_valid`=0 next cycle and the incoming instruction is dropped.
  - Opcode 1111111 → `o_illegal`=1 with all controls 0.
  - `rd`=x0 → `wb_en`=0.

Source files
------------

// File: rtl/bure_decode_stage.sv
// Bure RV32I decode stage: decodes fetch's instruction into the ALU operand/control
// bundle and holds it in one pipeline register with valid/ready handshakes on both sides.
module bure_decode_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [31:0]           i_instr,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic [4:0]            o_rs1_addr,
    output logic [4:0]            o_rs2_addr,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_force_add,
    output logic [2:0]            o_funct3,
    output logic [6:0]            o_funct7,
    output logic [DATA_WIDTH-1:0] o_data_lhs,
    output logic [DATA_WIDTH-1:0] o_data_rhs,
    output logic [4:0]            o_rd_addr,
    output logic                  o_wb_en,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_store_data,
    output logic                  o_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    function automatic logic signed [DATA_WIDTH-1:0] imm_i(input logic [31:0] instr);
        logic signed [11:0] imm;
        imm = instr[31:20];
        return DATA_WIDTH'(imm);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] imm_s(input logic [31:0] instr);
        logic signed [11:0] imm;
        imm = {instr[31:25], instr[11:7]};
        return DATA_WIDTH'(imm);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] imm_u(input logic [31:0] instr);
        logic signed [31:0] imm;
        imm = {instr[31:12], 12'b0};
        return DATA_WIDTH'(imm);
    endfunction

    logic [6:0]                   opcode;
    logic [2:0]                   funct3;
    logic                         is_shift;
    logic                         capture;

    logic                         force_add_d;
    logic [2:0]                   funct3_d;
    logic [6:0]                   funct7_d;
    logic signed [DATA_WIDTH-1:0] lhs_d;
    logic signed [DATA_WIDTH-1:0] rhs_d;
    logic                         wb_en_d;
    logic                         mem_read_d;
    logic                         mem_write_d;
    logic [DATA_WIDTH-1:0]        store_data_d;
    logic                         illegal_d;

    logic                         vld_p1;
    logic                         force_add_p1;
    logic [2:0]                   funct3_p1;
    logic [6:0]                   funct7_p1;
    logic signed [DATA_WIDTH-1:0] lhs_p1;
    logic signed [DATA_WIDTH-1:0] rhs_p1;
    logic [4:0]                   rd_p1;
    logic                         wb_en_p1;
    logic                         mem_read_p1;
    logic                         mem_write_p1;
    logic [DATA_WIDTH-1:0]        store_data_p1;
    logic                         illegal_p1;

    assign opcode     = i_instr[6:0];
    assign funct3     = i_instr[14:12];
    assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign o_rs1_addr = i_instr[19:15];
    assign o_rs2_addr = i_instr[24:20];

    assign o_ready = (!vld_p1 || i_ready) && !i_flush;
    assign capture = i_valid && o_ready;

    always_comb begin
        force_add_d  = 1'b0;
        funct3_d     = 3'b0;
        funct7_d     = 7'b0;
        lhs_d        = '0;
        rhs_d        = '0;
        wb_en_d      = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        store_data_d = '0;
        illegal_d    = 1'b0;
        case (opcode)
            OPC_OP: begin
                funct3_d = funct3;
                funct7_d = i_instr[31:25];
                lhs_d    = $signed(i_rs1_data);
                rhs_d    = $signed(i_rs2_data);
                wb_en_d  = 1'b1;
            end
            OPC_OP_IMM: begin
                funct3_d = funct3;
                lhs_d    = $signed(i_rs1_data);
                wb_en_d  = 1'b1;
                // Shifts carry the SRA/SRL selector in funct7, so rhs is the bare shamt;
                // other OP-IMM forms must not leak imm[11:5] into funct7 (ADDI vs SUB).
                if (is_shift) begin
                    funct7_d = i_instr[31:25];
                    rhs_d    = $signed(DATA_WIDTH'(i_instr[24:20]));
                end else begin
                    rhs_d    = imm_i(i_instr);
                end
            end
            OPC_LOAD: begin
                force_add_d = 1'b1;
                funct3_d    = funct3;
                lhs_d       = $signed(i_rs1_data);
                rhs_d       = imm_i(i_instr);
                mem_read_d  = 1'b1;
                wb_en_d     = 1'b1;
            end
            OPC_STORE: begin
                force_add_d  = 1'b1;
                funct3_d     = funct3;
                lhs_d        = $signed(i_rs1_data);
                rhs_d        = imm_s(i_instr);
                mem_write_d  = 1'b1;
                store_data_d = i_rs2_data;
            end
            OPC_LUI: begin
                force_add_d = 1'b1;
                rhs_d       = imm_u(i_instr);
                wb_en_d     = 1'b1;
            end
            OPC_AUIPC: begin
                force_add_d = 1'b1;
                lhs_d       = $signed(i_pc);
                rhs_d       = imm_u(i_instr);
                wb_en_d     = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
        if (i_instr[11:7] == 5'd0) begin
            wb_en_d = 1'b0;
        end
    end

    // Stage p1: decoded bundle register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1        <= 1'b0;
            force_add_p1  <= 1'b0;
            funct3_p1     <= 3'b0;
            funct7_p1     <= 7'b0;
            lhs_p1        <= '0;
            rhs_p1        <= '0;
            rd_p1         <= 5'b0;
            wb_en_p1      <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            store_data_p1 <= '0;
            illegal_p1    <= 1'b0;
        end else if (i_flush) begin
            vld_p1 <= 1'b0;
        end else if (capture) begin
            vld_p1        <= 1'b1;
            force_add_p1  <= force_add_d;
            funct3_p1     <= funct3_d;
            funct7_p1     <= funct7_d;
            lhs_p1        <= lhs_d;
            rhs_p1        <= rhs_d;
            rd_p1         <= i_instr[11:7];
            wb_en_p1      <= wb_en_d;
            mem_read_p1   <= mem_read_d;
            mem_write_p1  <= mem_write_d;
            store_data_p1 <= store_data_d;
            illegal_p1    <= illegal_d;
        end else if (vld_p1 && i_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign o_valid      = vld_p1;
    assign o_force_add  = force_add_p1;
    assign o_funct3     = funct3_p1;
    assign o_funct7     = funct7_p1;
    assign o_data_lhs   = lhs_p1;
    assign o_data_rhs   = rhs_p1;
    assign o_rd_addr    = rd_p1;
    assign o_wb_en      = wb_en_p1;
    assign o_mem_read   = mem_read_p1;
    assign o_mem_write  = mem_write_p1;
    assign o_store_data = store_data_p1;
    assign o_illegal    = illegal_p1;

endmodule

// File: tb/tb_bure_decode_stage.sv
// Directed bench for bure_decode_stage: inputs change on the falling edge,
// registered outputs are checked on the following falling edge.
module tb_bure_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic        o_force_add;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [31:0] o_data_lhs;
    logic [31:0] o_data_rhs;
    logic [4:0]  o_rd_addr;
    logic        o_wb_en;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [31:0] o_store_data;
    logic        o_illegal;

    int n_vec = 0;
    int n_err = 0;

    bure_decode_stage #(.DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_force_add(o_force_add),
        .o_funct3(o_funct3), .o_funct7(o_funct7), .o_data_lhs(o_data_lhs),
        .o_data_rhs(o_data_rhs), .o_rd_addr(o_rd_addr), .o_wb_en(o_wb_en),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_store_data(o_store_data), .o_illegal(o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        i_valid    = 1'b1;
        i_instr    = instr;
        i_pc       = pc;
        i_rs1_data = rs1;
        i_rs2_data = rs2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        n_vec++; if (o_illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b exp 0", o_illegal); end
        n_vec++; if (o_data_rhs !== 32'h0) begin n_err++; $display("FAIL reset_rhs got %h exp 0", o_data_rhs); end
        n_vec++; if (o_wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en got %b exp 0", o_wb_en); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_post got %b exp 0", o_valid); end
    endtask

    task automatic test_add();
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        #1;
        n_vec++; if (o_rs1_addr !== 5'd1) begin n_err++; $display("FAIL add_rs1_addr got %0d exp 1", o_rs1_addr); end
        n_vec++; if (o_rs2_addr !== 5'd2) begin n_err++; $display("FAIL add_rs2_addr got %0d exp 2", o_rs2_addr); end
        @(negedge clk);
        i_valid = 1'b0;
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b exp 1", o_valid); end
        n_vec++; if (o_funct3 !== 3'd0) begin n_err++; $display("FAIL add_funct3 got %0d exp 0", o_funct3); end
        n_vec++; if (o_funct7 !== 7'h00) begin n_err++; $display("FAIL add_funct7 got %h exp 00", o_funct7); end
        n_vec++; if (o_data_lhs !== 32'd5) begin n_err++; $display("FAIL add_lhs got %h exp 5", o_data_lhs); end
        n_vec++; if (o_data_rhs !== 32'd7) begin n_err++; $display("FAIL add_rhs got %h exp 7", o_data_rhs); end
        n_vec++; if (o_rd_addr !== 5'd3) begin n_err++; $display("FAIL add_rd got %0d exp 3", o_rd_addr); end
        n_vec++; if (o_wb_en !== 1'b1) begin n_err++; $display("FAIL add_wb_en got %b exp 1", o_wb_en); end
        n_vec++; if (o_force_add !== 1'b0) begin n_err++; $display("FAIL add_force_add got %b exp 0", o_force_add); end
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL add_drain got %b exp 0", o_valid); end
    endtask

    task automatic test_sub_addi();
        drive(32'h402081B3, 32'h0, 32'd9, 32'd4);
        @(negedge clk);
        n_vec++; if (o_funct7 !== 7'h20) begin n_err++; $display("FAIL sub_funct7 got %h exp 20", o_funct7); end
        drive(32'hFFF00093, 32'h0, 32'd0, 32'd0);
        @(negedge clk);
        n_vec++; if (o_data_rhs !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_rhs got %h exp ffffffff", o_data_rhs); end
        n_vec++; if (o_funct7 !== 7'h00) begin n_err++; $display("FAIL addi_funct7 got %h exp 00", o_funct7); end
        n_vec++; if (o_rd_addr !== 5'd1) begin n_err++; $display("FAIL addi_rd got %0d exp 1", o_rd_addr); end
        drive(32'h40008093, 32'h0, 32'h10, 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        n_vec++; if (o_funct7 !== 7'h00) begin n_err++; $display("FAIL addi400_funct7 got %h exp 00", o_funct7); end
        n_vec++; if (o_data_rhs !== 32'h400) begin n_err++; $display("FAIL addi400_rhs got %h exp 400", o_data_rhs); end
        n_vec++; if (o_data_lhs !== 32'h10) begin n_err++; $display("FAIL addi400_lhs got %h exp 10", o_data_lhs); end
    endtask

    task automatic test_srai_lui();
        drive(32'h40335293, 32'h0, 32'h80000000, 32'd0);
        @(negedge clk);
        n_vec++; if (o_funct3 !== 3'd5) begin n_err++; $display("FAIL srai_funct3 got %0d exp 5", o_funct3); end
        n_vec++; if (o_funct7 !== 7'h20) begin n_err++; $display("FAIL srai_funct7 got %h exp 20", o_funct7); end
        n_vec++; if (o_data_rhs !== 32'd3) begin n_err++; $display("FAIL srai_rhs got %h exp 3", o_data_rhs); end
        n_vec++; if (o_data_lhs !== 32'h80000000) begin n_err++; $display("FAIL srai_lhs got %h exp 80000000", o_data_lhs); end
        drive(32'h123450B7, 32'h40, 32'hAAAA, 32'd0);
        @(negedge clk);
        n_vec++; if (o_force_add !== 1'b1) begin n_err++; $display("FAIL lui_force_add got %b exp 1", o_force_add); end
        n_vec++; if (o_data_lhs !== 32'h0) begin n_err++; $display("FAIL lui_lhs got %h exp 0", o_data_lhs); end
        n_vec++; if (o_data_rhs !== 32'h12345000) begin n_err++; $display("FAIL lui_rhs got %h exp 12345000", o_data_rhs); end
        n_vec++; if (o_funct3 !== 3'd0) begin n_err++; $display("FAIL lui_funct3 got %0d exp 0", o_funct3); end
        n_vec++; if (o_wb_en !== 1'b1) begin n_err++; $display("FAIL lui_wb_en got %b exp 1", o_wb_en); end
        drive(32'h00001197, 32'h200, 32'hAAAA, 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        n_vec++; if (o_data_lhs !== 32'h200) begin n_err++; $display("FAIL auipc_lhs got %h exp 200", o_data_lhs); end
        n_vec++; if (o_data_rhs !== 32'h1000) begin n_err++; $display("FAIL auipc_rhs got %h exp 1000", o_data_rhs); end
        n_vec++; if (o_force_add !== 1'b1) begin n_err++; $display("FAIL auipc_force_add got %b exp 1", o_force_add); end
    endtask

    task automatic test_load_store();
        drive(32'h00812083, 32'h0, 32'h100, 32'h77);
        @(negedge clk);
        n_vec++; if (o_force_add !== 1'b1) begin n_err++; $display("FAIL lw_force_add got %b exp 1", o_force_add); end
        n_vec++; if (o_data_lhs !== 32'h100) begin n_err++; $display("FAIL lw_lhs got %h exp 100", o_data_lhs); end
        n_vec++; if (o_data_rhs !== 32'd8) begin n_err++; $display("FAIL lw_rhs got %h exp 8", o_data_rhs); end
        n_vec++; if (o_mem_read !== 1'b1) begin n_err++; $display("FAIL lw_mem_read got %b exp 1", o_mem_read); end
        n_vec++; if (o_mem_write !== 1'b0) begin n_err++; $display("FAIL lw_mem_write got %b exp 0", o_mem_write); end
        n_vec++; if (o_funct3 !== 3'd2) begin n_err++; $display("FAIL lw_funct3 got %0d exp 2", o_funct3); end
        n_vec++; if (o_wb_en !== 1'b1) begin n_err++; $display("FAIL lw_wb_en got %b exp 1", o_wb_en); end
        drive(32'h0020A623, 32'h0, 32'h40, 32'hDEAD);
        @(negedge clk);
        i_valid = 1'b0;
        n_vec++; if (o_data_rhs !== 32'd12) begin n_err++; $display("FAIL sw_rhs got %h exp c", o_data_rhs); end
        n_vec++; if (o_data_lhs !== 32'h40) begin n_err++; $display("FAIL sw_lhs got %h exp 40", o_data_lhs); end
        n_vec++; if (o_mem_write !== 1'b1) begin n_err++; $display("FAIL sw_mem_write got %b exp 1", o_mem_write); end
        n_vec++; if (o_mem_read !== 1'b0) begin n_err++; $display("FAIL sw_mem_read got %b exp 0", o_mem_read); end
        n_vec++; if (o_store_data !== 32'hDEAD) begin n_err++; $display("FAIL sw_store_data got %h exp dead", o_store_data); end
        n_vec++; if (o_wb_en !== 1'b0) begin n_err++; $display("FAIL sw_wb_en got %b exp 0", o_wb_en); end
        n_vec++; if (o_funct3 !== 3'd2) begin n_err++; $display("FAIL sw_funct3 got %0d exp 2", o_funct3); end
    endtask

    task automatic test_back_to_back();
        drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
        @(negedge clk);
        i_ready = 1'b0;
        drive(32'h00308233, 32'h0, 32'h11, 32'h22);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got %b exp 0", k, o_ready); end
            @(negedge clk);
            n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b exp 1", k, o_valid); end
            n_vec++; if (o_data_lhs !== 32'd1) begin n_err++; $display("FAIL bp_lhs[%0d] got %h exp 1", k, o_data_lhs); end
            n_vec++; if (o_rd_addr !== 5'd3) begin n_err++; $display("FAIL bp_rd[%0d] got %0d exp 3", k, o_rd_addr); end
        end
        i_ready = 1'b1;
        #1;
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b exp 1", o_ready); end
        @(negedge clk);
        n_vec++; if (o_data_lhs !== 32'h11) begin n_err++; $display("FAIL bp_release_lhs got %h exp 11", o_data_lhs); end
        n_vec++; if (o_rd_addr !== 5'd4) begin n_err++; $display("FAIL bp_release_rd got %0d exp 4", o_rd_addr); end
        for (int k = 0; k < 4; k++) begin
            drive(32'h00308233, 32'h0, 32'h100 + k, 32'd0);
            @(negedge clk);
            n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %b exp 1", k, o_valid); end
            n_vec++; if (o_data_lhs !== 32'h100 + k) begin n_err++; $display("FAIL b2b_lhs[%0d] got %h exp %h", k, o_data_lhs, 32'h100 + k); end
        end
        i_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", o_valid); end
    endtask

    task automatic test_flush();
        drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid got %b exp 1", o_valid); end
        i_flush = 1'b1;
        drive(32'h123450B7, 32'h0, 32'd0, 32'd0);
        #1;
        n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b exp 0", o_ready); end
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b exp 0", o_valid); end
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped got %b exp 0", o_valid); end
    endtask

    task automatic test_illegal();
        drive(32'hFFFFFFFF, 32'h80, 32'h55, 32'h66);
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL ill_valid got %b exp 1", o_valid); end
        n_vec++; if (o_illegal !== 1'b1) begin n_err++; $display("FAIL ill_illegal got %b exp 1", o_illegal); end
        n_vec++; if (o_wb_en !== 1'b0) begin n_err++; $display("FAIL ill_wb_en got %b exp 0", o_wb_en); end
        n_vec++; if ({o_mem_read, o_mem_write, o_force_add} !== 3'b000) begin n_err++; $display("FAIL ill_ctrl got %b exp 000", {o_mem_read, o_mem_write, o_force_add}); end
        n_vec++; if (o_funct3 !== 3'd0) begin n_err++; $display("FAIL ill_funct3 got %0d exp 0", o_funct3); end
        n_vec++; if (o_funct7 !== 7'd0) begin n_err++; $display("FAIL ill_funct7 got %h exp 0", o_funct7); end
        n_vec++; if (o_data_lhs !== 32'h0) begin n_err++; $display("FAIL ill_lhs got %h exp 0", o_data_lhs); end
        n_vec++; if (o_data_rhs !== 32'h0) begin n_err++; $display("FAIL ill_rhs got %h exp 0", o_data_rhs); end
        n_vec++; if (o_store_data !== 32'h0) begin n_err++; $display("FAIL ill_store_data got %h exp 0", o_store_data); end
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        @(negedge clk);
        i_valid = 1'b0;
        n_vec++; if (o_illegal !== 1'b0) begin n_err++; $display("FAIL ill_clear got %b exp 0", o_illegal); end
    endtask

    task automatic test_rd_x0();
        drive(32'h00208033, 32'h0, 32'd5, 32'd7);
        @(negedge clk);
        n_vec++; if (o_wb_en !== 1'b0) begin n_err++; $display("FAIL x0_add_wb_en got %b exp 0", o_wb_en); end
        n_vec++; if (o_rd_addr !== 5'd0) begin n_err++; $display("FAIL x0_add_rd got %0d exp 0", o_rd_addr); end
        drive(32'h12345037, 32'h0, 32'd0, 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        n_vec++; if (o_wb_en !== 1'b0) begin n_err++; $display("FAIL x0_lui_wb_en got %b exp 0", o_wb_en); end
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL x0_lui_valid got %b exp 1", o_valid); end
    endtask

    task automatic test_async_reset();
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got %b exp 0", o_valid); end
        n_vec++; if (o_data_lhs !== 32'h0) begin n_err++; $display("FAIL areset_lhs got %h exp 0", o_data_lhs); end
        @(negedge clk);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL areset_post_valid got %b exp 0", o_valid); end
    endtask

    initial begin
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_instr    = 32'h0;
        i_pc       = 32'h0;
        i_rs1_data = 32'h0;
        i_rs2_data = 32'h0;
        i_flush    = 1'b0;
        i_ready    = 1'b1;
        test_reset();
        test_add();
        test_sub_addi();
        test_srai_lui();
        test_load_store();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_rd_x0();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
